// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: owner encoding, response-tag type and default memory latency
package mem_arbiter_pkg;
   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_D = 1'b1;
   localparam int DEFAULT_MEM_LATENCY = 1;
   typedef struct packed {
      logic valid;
      logic owner;
   } resp_tag_t;
endpackage

// File: rtl/mem_arbiter_resp_tag_pipe.sv
// resp_tag_pipe: DEPTH-stage shift register carrying read tags alongside the memory latency
module resp_tag_pipe import mem_arbiter_pkg::*; #(
   parameter int DEPTH = DEFAULT_MEM_LATENCY
) (
   input  logic      clk,
   input  logic      reset,
   input  resp_tag_t tag_in,
   output resp_tag_t tag_out
);
   resp_tag_t stages [DEPTH];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      end else begin
         stages[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end
   assign tag_out = stages[DEPTH-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter for fetch/data ports sharing one synchronous memory.
// Define MEM_ARB_STARVE_EN to force a fetch grant after STARVE_LIMIT denied fetch cycles.
module mem_arbiter import mem_arbiter_pkg::*; #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);
   logic force_if;
   resp_tag_t tag_in, tag_out;
`ifdef MEM_ARB_STARVE_EN
   localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
   logic [SW-1:0] starve_cnt;
   assign force_if = starve_cnt == SW'(STARVE_LIMIT);
   always_ff @(posedge clk) begin
      if (reset || !if_req || if_gnt) starve_cnt <= '0;
      else if (!force_if) starve_cnt <= starve_cnt + SW'(1);
   end
`else
   assign force_if = 1'b0;
`endif
   always_comb begin
      d_gnt     = !reset && d_req && !(if_req && force_if);
      if_gnt    = !reset && if_req && !d_gnt;
      mem_en    = d_gnt || if_gnt;
      mem_we    = d_gnt && d_we;
      mem_addr  = d_gnt ? d_addr : if_addr;
      mem_wdata = d_wdata;
      mem_be    = d_gnt ? d_be : if_gnt ? '1 : '0;
      tag_in    = '{valid: mem_en && !mem_we, owner: d_gnt ? OWNER_D : OWNER_IF};
   end
   resp_tag_pipe #(.DEPTH(MEM_LATENCY)) u_pipe (
      .clk(clk), .reset(reset), .tag_in(tag_in), .tag_out(tag_out)
   );
   assign if_rvalid = tag_out.valid && tag_out.owner == OWNER_IF;
   assign d_rvalid  = tag_out.valid && tag_out.owner == OWNER_D;
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at latency 1 (u1) and latency 3 (u3).
module tb_mem_arbiter;
   logic clk = 0, reset = 1;
   logic if_req = 0, d_req = 0, d_we = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0] d_be = 0;
   logic if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [3:0] mem_be1;
   logic if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3;
   logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
   logic [3:0] mem_be3;
   logic [31:0] mem1 [256];
   logic [31:0] mem3 [256];
   logic [31:0] r3a, r3b;
   int checks = 0, errors = 0;
   bit starve_en;
   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u1 (
      .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
      .if_rvalid(if_rvalid1), .if_rdata(if_rdata1), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_be(mem_be1), .mem_rdata(mem_rdata1));
   mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u3 (
      .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
      .if_rvalid(if_rvalid3), .if_rdata(if_rdata3), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_be(mem_be3), .mem_rdata(mem_rdata3));

   // Behavioural byte-enabled memories with latency 1 and 3
   always @(posedge clk) begin
      if (mem_en1 && mem_we1) begin
         for (int b = 0; b < 4; b++) if (mem_be1[b]) mem1[mem_addr1[9:2]][8*b +: 8] <= mem_wdata1[8*b +: 8];
      end else if (mem_en1) mem_rdata1 <= mem1[mem_addr1[9:2]];
      if (mem_en3 && mem_we3) begin
         for (int b = 0; b < 4; b++) if (mem_be3[b]) mem3[mem_addr3[9:2]][8*b +: 8] <= mem_wdata3[8*b +: 8];
      end else if (mem_en3) r3a <= mem3[mem_addr3[9:2]];
      r3b <= r3a;
      mem_rdata3 <= r3b;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef MEM_ARB_STARVE_EN
      starve_en = 1;
`else
      starve_en = 0;
`endif
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 0;
         mem3[i] = 0;
      end
      mem1[8'h40] = 32'hDEADBEEF; mem3[8'h40] = 32'hDEADBEEF;
      mem1[8'h10] = 32'hAABBCCDD; mem3[8'h10] = 32'hAABBCCDD;
      if_addr = 32'h100; d_addr = 32'h40;
      if_req = 1; d_req = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_if_gnt", if_gnt1, 0);
         chk("rst_d_gnt", d_gnt1, 0);
         chk("rst_mem_en", mem_en1, 0);
         chk("rst_if_rvalid", if_rvalid1, 0);
         chk("rst_d_rvalid", d_rvalid1, 0);
      end
      reset = 0;
      #1;
      chk("rel_d_gnt", d_gnt1, 1);
      chk("rel_if_gnt", if_gnt1, 0);
      chk("rel_mem_addr", mem_addr1, 32'h40);
      step();
      d_req = 0;
      #1;
      chk("sim_d_rvalid", d_rvalid1, 1);
      chk("sim_d_rdata", d_rdata1, 32'hAABBCCDD);
      chk("sim_if_rvalid", if_rvalid1, 0);
      chk("sim_if_gnt", if_gnt1, 1);
      chk("fetch_mem_addr", mem_addr1, 32'h100);
      chk("fetch_mem_we", mem_we1, 0);
      chk("fetch_mem_be", mem_be1, 4'hF);
      step();
      if_req = 0;
      #1;
      chk("fetch_if_rvalid", if_rvalid1, 1);
      chk("fetch_if_rdata", if_rdata1, 32'hDEADBEEF);
      chk("fetch_d_rvalid", d_rvalid1, 0);
      chk("idle_mem_en", mem_en1, 0);
      chk("idle_mem_be", mem_be1, 0);
      step();
      d_req = 1; d_we = 1; d_wdata = 32'h12345678; d_be = 4'b0011;
      #1;
      chk("st_d_gnt", d_gnt1, 1);
      chk("st_mem_we", mem_we1, 1);
      chk("st_mem_be", mem_be1, 4'b0011);
      chk("st_mem_wdata", mem_wdata1, 32'h12345678);
      chk("st_mem_addr", mem_addr1, 32'h40);
      step();
      d_we = 0;
      #1;
      chk("st_no_rvalid", d_rvalid1, 0);
      chk("ld_mem_we", mem_we1, 0);
      step();
      d_req = 0;
      #1;
      chk("ld_d_rvalid", d_rvalid1, 1);
      chk("ld_merged", d_rdata1, 32'hAABB5678);
      step();
      chk("ld_done", d_rvalid1, 0);
      chk("u3_ld_rvalid_early", d_rvalid3, 0);
      step();
      chk("u3_ld_rvalid", d_rvalid3, 1);
      chk("u3_ld_rdata", d_rdata3, 32'hAABB5678);
      step();
      chk("u3_ld_done", d_rvalid3, 0);
      // Continuous contention: with anti-starvation, every fifth grant goes to fetch
      if_req = 1; d_req = 1;
      for (int i = 0; i < 10; i++) begin
         logic exp_if;
         logic prev_if;
         exp_if = starve_en && (i % 5 == 4);
         prev_if = starve_en && (i % 5 == 0) && i > 0;
         #1;
         chk($sformatf("stv_if_gnt%0d", i), if_gnt1, exp_if);
         chk($sformatf("stv_d_gnt%0d", i), d_gnt1, !exp_if);
         if (i > 0) begin
            chk($sformatf("stv_if_rv%0d", i), if_rvalid1, prev_if);
            chk($sformatf("stv_d_rv%0d", i), d_rvalid1, !prev_if);
            chk($sformatf("stv_rdata%0d", i), d_rvalid1 ? d_rdata1 : if_rdata1,
                prev_if ? 32'hDEADBEEF : 32'hAABB5678);
         end
         step();
      end
      if_req = 0; d_req = 0;
      for (int i = 0; i < 4; i++) step();
      // Two reads granted, then reset before either returns at latency 3
      d_req = 1;
      step();
      step();
      d_req = 0; reset = 1;
      step();
      reset = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("flush_d_rv%0d", i), d_rvalid3, 0);
         chk($sformatf("flush_if_rv%0d", i), if_rvalid3, 0);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter sharing one single-port synchronous unified memory between the instruction-fetch port and the load/store data port of the RISC-V core. It grants at most one access per cycle, and gives priority to data. An optional anti-starvation counter forces a fetch grant. A response-tag pipeline routes each read result back to the port that issued it, after a fixed memory latency.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width (byte enables are DATA_WIDTH/8 bits)
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; must be ≥1
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_WIDTH  load data
- mem_en, mem_we  out  1  memory access strobe and write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- **Grant logic** is combinational from the requests and the starvation state.
  - Only d_req: data is granted.
  - Only if_req: fetch is granted.
  - Both: data wins unless starve_cnt == STARVE_LIMIT; then fetch wins.
- **Granted access**:
  - mem_en=1.
  - mem_addr is taken from the granted port.
  - Fetch grant: mem_we=0, mem_be all ones.
  - Data grant: mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata.
- **No grant**: mem_en=0; mem_we=0, mem_be=0.
- **Requester rule**: a requester holds req/addr/data stable until it sees gnt. It may drop req without a grant.
- **Response-tag pipeline**, MEM_LATENCY stages:
  - Stage 0 is loaded with {valid = granted read, owner}.
  - The pipeline shifts every cycle.
  - At the last stage, valid asserts if_rvalid or d_rvalid according to owner.
- **Responses**:
  - Stores produce no response.
  - if_rdata and d_rdata are both wired to mem_rdata; each is meaningful only with its rvalid.
  - Reads complete in issue order.
- **Starvation counter** (starve_cnt, width clog2(STARVE_LIMIT+1)):
  - Increments when if_req && !if_gnt, saturating at STARVE_LIMIT.
  - Clears on if_gnt or !if_req.

## Timing
- Grant and memory command are asserted in the same cycle as the request (zero latency).
- Read data returns exactly MEM_LATENCY cycles after the grant. Throughput is one access per cycle.
- **During reset**: if_gnt=d_gnt=mem_en=0.
- **Registered outputs after reset**: if_rvalid=d_rvalid=0, tag pipeline cleared, starve_cnt=0.
- **Reset mid-operation**: in-flight read responses are discarded; no rvalid appears for them.
- Back-to-back grants to alternating owners return data in alternating order with no bubble.
- STARVE_LIMIT=0: fetch wins every tie.

## Configuration
- **MEM_ARB_STARVE_EN defined**: starvation counter and forced fetch grant as above.
- **Not defined**: strict data priority. starve_cnt and its logic are absent, and STARVE_LIMIT is ignored.

## Structure
- **Shared package**:
  - owner encoding constants OWNER_IF=1'b0, OWNER_D=1'b1
  - the response-tag struct/typedef {valid, owner}
  - default MEM_LATENCY
- **Sub-module resp_tag_pipe**: parameterised by depth; holds the shift register of tags and the synchronous clear.

## Test plan
- **Reset release**: reset=1 for 3 cycles with both requests high -> no gnt, mem_en=0, no rvalid; first cycle after reset, d_gnt=1.
- **Lone fetch**: if_req at 0x100 with MEM_LATENCY=1 and memory word 0xDEADBEEF -> if_gnt same cycle; if_rvalid=1 and if_rdata=0xDEADBEEF next cycle; d_rvalid=0.
- **Simultaneous requests**: both requesting, d_we=0 -> d_gnt=1, if_gnt=0; d_rvalid after latency; fetch granted the following cycle once d_req drops.
- **Starvation** (MEM_ARB_STARVE_EN, STARVE_LIMIT=4): both requesting continuously -> pattern of 4 data grants then 1 fetch grant, repeating. Without the macro, fetch is never granted.
- **Store**: d_we=1, d_be=4'b0011, addr 0x40 -> mem_we=1, mem_be=0011; no d_rvalid; a load of 0x40 then returns the merged word.
- **Reset with reads in flight**: MEM_LATENCY=3, assert reset 1 cycle after two read grants -> no rvalid is ever produced for them.
